rf_wb_arbiter: RTL and testbench

//  Sequences the single register-file write port of the SISC datapath between two writeback sources:

---
 rtl/sisc_wb_pkg.sv | 16 +
 rtl/wb_slot.sv | 32 +++
 rtl/rf_wb_arbiter.sv | 105 ++++++++++
 tb/tb_rf_wb_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/sisc_wb_pkg.sv
// Shared writeback types and constants for the SISC register-file write port.
package sisc_wb_pkg;

  localparam int WB_DW = 32;
  localparam int WB_AW = 4;

  localparam logic WB_SEL_A = 1'b0;
  localparam logic WB_SEL_B = 1'b1;

  typedef struct packed {
    logic             valid;
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_slot.sv
// One-entry writeback buffer; a load on the same edge as a clear wins so a slot can drain and refill.
module wb_slot #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          clear,
  input  logic [AW-1:0] load_addr,
  input  logic [DW-1:0] load_data,
  output logic          valid,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data
);

  // Addr/data only change on a load, so a waiting entry stays stable until granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      addr  <= load_addr;
      data  <= load_data;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the single register-file write port between the ALU (A) and load (B) writeback sources,
// granting buffered entries in arrival order.
module rf_wb_arbiter
  import sisc_wb_pkg::*;
#(
  parameter int DW     = WB_DW,
  parameter int AW     = WB_AW,
  parameter bit PRIO_B = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic [DW-1:0] mux_in_a,
  output logic [DW-1:0] mux_in_b,
  output logic          mux_sel,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic          busy
);

  logic          sa_valid, sb_valid;
  logic [AW-1:0] sa_addr, sb_addr;
  logic [DW-1:0] sa_data, sb_data;
  logic          a_older;
  logic          grant_a, grant_b;
  logic          load_a, load_b;
  logic          next_a_valid, next_b_valid;

  // Grant depends only on slot state; reset suppresses it so pending entries are never written.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst) begin
      if (sa_valid && (!sb_valid || a_older))
        grant_a = 1'b1;
      else if (sb_valid)
        grant_b = 1'b1;
    end
  end

  assign a_ready = rst | ~sa_valid | grant_a;
  assign b_ready = rst | ~sb_valid | grant_b;
  assign load_a  = a_valid & a_ready & ~rst;
  assign load_b  = b_valid & b_ready & ~rst;

  assign next_a_valid = load_a | (sa_valid & ~grant_a);
  assign next_b_valid = load_b | (sb_valid & ~grant_b);

  wb_slot #(.DW(DW), .AW(AW)) u_slot_a (
    .clk       (clk),
    .rst       (rst),
    .load      (load_a),
    .clear     (grant_a),
    .load_addr (a_addr),
    .load_data (a_data),
    .valid     (sa_valid),
    .addr      (sa_addr),
    .data      (sa_data)
  );

  wb_slot #(.DW(DW), .AW(AW)) u_slot_b (
    .clk       (clk),
    .rst       (rst),
    .load      (load_b),
    .clear     (grant_b),
    .load_addr (b_addr),
    .load_data (b_data),
    .valid     (sb_valid),
    .addr      (sb_addr),
    .data      (sb_data)
  );

  // A fresh entry joining a still-occupied pair is younger; a simultaneous pair falls to PRIO_B.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_older <= ~PRIO_B;
    end else if (load_a && load_b) begin
      a_older <= ~PRIO_B;
    end else if (next_a_valid && next_b_valid) begin
      if (load_a)
        a_older <= 1'b0;
      else if (load_b)
        a_older <= 1'b1;
    end else if (next_a_valid) begin
      a_older <= 1'b1;
    end else if (next_b_valid) begin
      a_older <= 1'b0;
    end
  end

  assign rf_we    = grant_a | grant_b;
  assign mux_sel  = grant_b ? WB_SEL_B : WB_SEL_A;
  assign rf_waddr = grant_b ? sb_addr : (grant_a ? sa_addr : '0);
  assign mux_in_a = sa_data;
  assign mux_in_b = sb_data;
  assign busy     = sa_valid | sb_valid;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios then random traffic, checked against an
// arrival-ordered queue model and a shadow register file.
module tb_rf_wb_arbiter;

  localparam bit PRIO_B = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [3:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic [31:0] mux_in_a, mux_in_b;
  logic        mux_sel, rf_we, busy;
  logic [3:0]  rf_waddr;

  typedef struct {
    bit          ch;
    logic [3:0]  addr;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic [31:0] exp_rf[16];
  logic [31:0] act_rf[16];
  int          checks = 0;
  int          errors = 0;

  rf_wb_arbiter #(.DW(32), .AW(4), .PRIO_B(PRIO_B)) dut (
    .clk      (clk),
    .rst      (rst),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_addr   (a_addr),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_addr   (b_addr),
    .b_data   (b_data),
    .mux_in_a (mux_in_a),
    .mux_in_b (mux_in_b),
    .mux_sel  (mux_sel),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Shadow register file built from what the DUT actually presents on the write port.
  always @(negedge clk) begin
    if (rf_we === 1'b1)
      act_rf[rf_waddr] <= mux_sel ? mux_in_b : mux_in_a;
  end

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A channel may accept unless its previous entry is still waiting behind an older one.
  function automatic bit chanReady(input bit ch);
    if (rst) return 1'b1;
    foreach (q[i])
      if (q[i].ch == ch && i != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic checkOutput();
    bit   ew;
    ent_t f;
    @(negedge clk);
    ew = (!rst && q.size() > 0);
    cmp("rf_we", 32'(rf_we), 32'(ew));
    if (ew) begin
      f = q[0];
      cmp("rf_waddr", 32'(rf_waddr), 32'(f.addr));
      cmp("mux_sel", 32'(mux_sel), 32'(f.ch));
      cmp("wb_data", mux_sel ? mux_in_b : mux_in_a, f.data);
    end else begin
      cmp("rf_waddr_idle", 32'(rf_waddr), 32'd0);
      cmp("mux_sel_idle", 32'(mux_sel), 32'd0);
    end
    cmp("a_ready", 32'(a_ready), 32'(chanReady(1'b0)));
    cmp("b_ready", 32'(b_ready), 32'(chanReady(1'b1)));
    cmp("busy", 32'(busy), 32'(q.size() > 0));
  endtask

  task automatic modelUpdate();
    bit   ra, rb, acc_a, acc_b;
    ent_t ea, eb;
    ra = chanReady(1'b0);
    rb = chanReady(1'b1);
    if (rst) begin
      q.delete();
    end else begin
      if (q.size() > 0) begin
        exp_rf[q[0].addr] = q[0].data;
        void'(q.pop_front());
      end
      acc_a = a_valid && ra;
      acc_b = b_valid && rb;
      ea = '{ch: 1'b0, addr: a_addr, data: a_data};
      eb = '{ch: 1'b1, addr: b_addr, data: b_data};
      if (acc_a && acc_b) begin
        if (PRIO_B) begin q.push_back(eb); q.push_back(ea); end
        else        begin q.push_back(ea); q.push_back(eb); end
      end else if (acc_a) begin
        q.push_back(ea);
      end else if (acc_b) begin
        q.push_back(eb);
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic av, input logic [3:0] aa,
                               input logic [31:0] ad, input logic bv, input logic [3:0] ba,
                               input logic [31:0] bd);
    rst = r; a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    checkOutput();
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      exp_rf[i] = 32'd0;
      act_rf[i] = 32'd0;
    end
    rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
    a_addr = 4'd1; a_data = 32'h11; b_addr = 4'd2; b_data = 32'h22;
    @(posedge clk);
    #1;

    // Reset held with both requests asserted: nothing accepted, nothing written.
    applyStimulus(1'b1, 1'b1, 4'd1, 32'h11, 1'b1, 4'd2, 32'h22);
    applyStimulus(1'b1, 1'b1, 4'd1, 32'h11, 1'b1, 4'd2, 32'h22);
    cmp("reset_mux_in_a", mux_in_a, 32'd0);
    cmp("reset_mux_in_b", mux_in_b, 32'd0);
    idle(1);

    // Single A write.
    applyStimulus(1'b0, 1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 32'd0);
    idle(2);
    cmp("rf_r3", act_rf[3], 32'hDEADBEEF);

    // Back-to-back A on consecutive cycles.
    for (int i = 1; i <= 4; i++)
      applyStimulus(1'b0, 1'b1, 4'(i), 32'h100 + 32'(i), 1'b0, 4'd0, 32'd0);
    idle(2);

    // Simultaneous A and B to r5: B is older, so A's value lands last.
    applyStimulus(1'b0, 1'b1, 4'd5, 32'h1, 1'b1, 4'd5, 32'h2);
    idle(3);
    cmp("rf_r5", act_rf[5], 32'h1);

    // Staggered B, A, B.
    applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd7, 32'h70);
    applyStimulus(1'b0, 1'b1, 4'd8, 32'h80, 1'b0, 4'd0, 32'd0);
    applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd9, 32'h90);
    idle(2);

    // Reset with both slots full: pending writes vanish.
    applyStimulus(1'b0, 1'b1, 4'd10, 32'hAAAA, 1'b1, 4'd11, 32'hBBBB);
    applyStimulus(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    idle(2);
    cmp("rf_r10_dropped", act_rf[10], 32'd0);

    // Random traffic with rare resets.
    for (int i = 0; i < 400; i++)
      applyStimulus(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)), $urandom,
                    1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
    idle(3);

    for (int i = 0; i < 16; i++)
      cmp($sformatf("rf_r%0d", i), act_rf[i], exp_rf[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
